param_divider: RTL and testbench

PARAM_DIVIDER -- requirements
Module: param_divider

---
 rtl/div_pkg.sv | 19 +
 rtl/div_step.sv | 60 ++++++
 rtl/param_divider.sv | 169 ++++++++++++++++
 tb/tb_param_divider.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the parameterised shift/subtract divider:
// FSM state encoding, algorithm-select constants and the length-field
// width helper.
package div_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_FIN  = 2'd3;

  localparam logic MODE_RESTORING    = 1'b0;
  localparam logic MODE_NONRESTORING = 1'b1;

  // Bits needed to hold a bit count in the range 0..width.
  function automatic int calc_lw(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 division iteration, purely combinational.
// The partial remainder is WIDTH+1 bits signed. Internally one extra bit
// is carried so that 2R +/- D never wraps. That matters in non-restoring
// mode, where R can reach -D. The result always fits back into WIDTH+1 bits.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic signed [WIDTH:0]   r_in,
  input  logic                    bit_in,
  input  logic        [WIDTH-1:0] divisor,
  input  logic                    mode,
  output logic signed [WIDTH:0]   r_out,
  output logic                    q_bit,
  output logic                    add_stb,
  output logic                    sub_stb
);

  logic signed [WIDTH+1:0] shifted;
  logic signed [WIDTH+1:0] dvs;
  logic signed [WIDTH+1:0] trial;
  logic signed [WIDTH+1:0] result;

  // Shift in the next dividend bit, then subtract/add the divisor as the algorithm dictates
  always_comb begin
    shifted = $signed({r_in, bit_in});
    dvs     = $signed({2'b00, divisor});
    trial   = '0;
    result  = '0;
    add_stb = 1'b0;
    sub_stb = 1'b0;
    q_bit   = 1'b0;
    if (mode == MODE_RESTORING) begin
      trial   = shifted - dvs;
      sub_stb = 1'b1;
      if (trial < 0) begin
        // Undo the subtraction with a real add so the add counter reflects adder use
        result  = trial + dvs;
        add_stb = 1'b1;
        q_bit   = 1'b0;
      end else begin
        result  = trial;
        q_bit   = 1'b1;
      end
    end else begin
      // Non-restoring: the sign of the previous remainder picks the operation
      if (!r_in[WIDTH]) begin
        result  = shifted - dvs;
        sub_stb = 1'b1;
      end else begin
        result  = shifted + dvs;
        add_stb = 1'b1;
      end
      q_bit = ~result[WIDTH+1];
    end
    r_out = $signed(result[WIDTH:0]);
  end

endmodule

// File: rtl/param_divider.sv
// Parameterised unsigned divider offering restoring and non-restoring
// algorithms. Each iteration takes one cycle. The operation walks
// IDLE -> RUN (L cycles) -> FIX -> FIN.
// A zero divisor, or a divisor longer than the dividend, skips straight to FIN.
// Results and adder-usage counters stay on the outputs until the next
// accepted start.
module param_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LW    = calc_lw(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic [LW-1:0]    dividend_length,
  input  logic [LW-1:0]    divisor_length,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic [LW:0]      add_count,
  output logic [LW:0]      sub_count,
  output logic             dbz
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [LW-1:0] WIDTH_L = LW'(WIDTH);

  logic [1:0]              state;
  logic [LW-1:0]           rem_cnt;
  logic [LW-1:0]           len_l;
  logic [IW-1:0]           bit_idx;
  logic                    cur_bit;

  logic signed [WIDTH:0]   r_q;
  logic        [WIDTH-1:0] q_acc;
  logic        [WIDTH-1:0] dvd_q;
  logic        [WIDTH-1:0] dsr_q;
  logic                    mode_q;

  logic signed [WIDTH:0]   step_r;
  logic                    step_q;
  logic                    step_add;
  logic                    step_sub;

  logic signed [WIDTH:0]   r_fix;
  logic                    fix_add;

  assign ready = (state == ST_IDLE);

  // A zero length, or one larger than the operand, means "use all WIDTH bits"
  always_comb begin
    len_l = dividend_length;
    if (dividend_length == '0 || dividend_length > WIDTH_L) begin
      len_l = WIDTH_L;
    end
  end

  // rem_cnt counts bits still to consume, so the current bit sits at rem_cnt-1
  always_comb begin
    bit_idx = IW'(rem_cnt - LW'(1));
    cur_bit = dvd_q[bit_idx];
  end

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .r_in    (r_q),
    .bit_in  (cur_bit),
    .divisor (dsr_q),
    .mode    (mode_q),
    .r_out   (step_r),
    .q_bit   (step_q),
    .add_stb (step_add),
    .sub_stb (step_sub)
  );

  // Final correction: a negative non-restoring remainder needs one add-back
  always_comb begin
    r_fix   = r_q;
    fix_add = 1'b0;
    if (mode_q == MODE_NONRESTORING && r_q[WIDTH]) begin
      r_fix   = r_q + $signed({1'b0, dsr_q});
      fix_add = 1'b1;
    end
  end

  // Control FSM, counters and held result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      rem_cnt   <= '0;
      done      <= 1'b0;
      dbz       <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      add_count <= '0;
      sub_count <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            add_count <= '0;
            sub_count <= '0;
            dbz       <= 1'b0;
            rem_cnt   <= len_l;
            if (divisor == '0) begin
              dbz       <= 1'b1;
              quotient  <= '1;
              remainder <= dividend;
              done      <= 1'b1;
              state     <= ST_FIN;
            end else if (divisor_length > len_l) begin
              quotient  <= '0;
              remainder <= dividend;
              done      <= 1'b1;
              state     <= ST_FIN;
            end else begin
              state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          add_count <= add_count + {{LW{1'b0}}, step_add};
          sub_count <= sub_count + {{LW{1'b0}}, step_sub};
          rem_cnt   <= rem_cnt - LW'(1);
          if (rem_cnt == LW'(1)) begin
            state <= ST_FIX;
          end
        end
        ST_FIX: begin
          add_count <= add_count + {{LW{1'b0}}, fix_add};
          quotient  <= q_acc;
          remainder <= r_fix[WIDTH-1:0];
          done      <= 1'b1;
          state     <= ST_FIN;
        end
        ST_FIN: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Datapath registers: operands latched on accept, remainder/quotient built during RUN
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && start) begin
      r_q    <= '0;
      q_acc  <= '0;
      dvd_q  <= dividend;
      dsr_q  <= divisor;
      mode_q <= mode;
    end else if (state == ST_RUN) begin
      r_q   <= step_r;
      q_acc <= {q_acc[WIDTH-2:0], step_q};
    end else if (state == ST_FIX) begin
      r_q <= r_fix;
    end
  end

endmodule

// File: tb/tb_param_divider.sv
// Bench for param_divider. The WIDTH=32 instance handles the directed table,
// reset, back-to-back and random work; a WIDTH=8 instance gets a random sweep.
// Expected results are queued at issue time and compared when done pulses.
module tb_param_divider;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b1;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  logic        s32, m32, rdy32, dn32, dbz32;
  logic [31:0] a32, b32, q32, r32;
  logic [5:0]  al32, bl32;
  logic [6:0]  ac32, sc32;

  logic        s8, m8, rdy8, dn8, dbz8;
  logic [7:0]  a8, b8, q8, r8;
  logic [3:0]  al8, bl8;
  logic [4:0]  ac8, sc8;

  param_divider #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(s32), .mode(m32),
    .dividend(a32), .divisor(b32), .dividend_length(al32), .divisor_length(bl32),
    .ready(rdy32), .done(dn32), .quotient(q32), .remainder(r32),
    .add_count(ac32), .sub_count(sc32), .dbz(dbz32)
  );

  param_divider #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(s8), .mode(m8),
    .dividend(a8), .divisor(b8), .dividend_length(al8), .divisor_length(bl8),
    .ready(rdy8), .done(dn8), .quotient(q8), .remainder(r8),
    .add_count(ac8), .sub_count(sc8), .dbz(dbz8)
  );

  typedef struct {
    logic [63:0] q;
    logic [63:0] r;
    logic        dbz;
    int          add;
    int          sub;
    int          lat;
    int          scyc;
  } exp_t;

  typedef struct {
    logic        m;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  al;
    logic [5:0]  bl;
    logic [31:0] eq;
    logic [31:0] er;
    logic        ed;
    int          ea;
    int          es;
    int          el;
  } tv_t;

  exp_t sb32[$];
  exp_t sb8[$];
  int   n32 = 0;
  int   n8  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  // Reference: true division plus closed-form adder counts derived from quotient bits
  function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                 input logic m);
    exp_t        e;
    logic [63:0] mask;
    logic [63:0] qv;
    mask   = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    e.scyc = 0;
    if (b == 0) begin
      e.q = mask; e.r = a; e.dbz = 1'b1; e.add = 0; e.sub = 0; e.lat = 1;
    end else begin
      qv    = a / b;
      e.q   = qv;
      e.r   = a % b;
      e.dbz = 1'b0;
      e.lat = w + 2;
      if (!m) begin
        e.sub = w;
        e.add = w - $countones(qv);
      end else begin
        e.sub = 1 + $countones(qv >> 1);
        e.add = w - e.sub + (qv[0] ? 0 : 1);
      end
    end
    return e;
  endfunction

  always @(negedge clk) begin : mon32
    exp_t e;
    if (dn32 === 1'b1) begin
      if (sb32.size() == 0) begin
        fail_now($sformatf("unexpected_done32 at cycle %0d", cyc));
      end else begin
        e = sb32.pop_front();
        check($sformatf("op32_%0d_quotient", n32), {32'b0, q32}, e.q);
        check($sformatf("op32_%0d_remainder", n32), {32'b0, r32}, e.r);
        check($sformatf("op32_%0d_dbz", n32), {63'b0, dbz32}, {63'b0, e.dbz});
        check($sformatf("op32_%0d_add_count", n32), {57'b0, ac32}, 64'(e.add));
        check($sformatf("op32_%0d_sub_count", n32), {57'b0, sc32}, 64'(e.sub));
        check($sformatf("op32_%0d_latency", n32), 64'(cyc - e.scyc), 64'(e.lat));
        check($sformatf("op32_%0d_ready_at_done", n32), {63'b0, rdy32}, 64'd0);
        n32++;
      end
    end
  end

  always @(negedge clk) begin : mon8
    exp_t e;
    if (dn8 === 1'b1) begin
      if (sb8.size() == 0) begin
        fail_now($sformatf("unexpected_done8 at cycle %0d", cyc));
      end else begin
        e = sb8.pop_front();
        check($sformatf("op8_%0d_quotient", n8), {56'b0, q8}, e.q);
        check($sformatf("op8_%0d_remainder", n8), {56'b0, r8}, e.r);
        check($sformatf("op8_%0d_dbz", n8), {63'b0, dbz8}, {63'b0, e.dbz});
        check($sformatf("op8_%0d_add_count", n8), {59'b0, ac8}, 64'(e.add));
        check($sformatf("op8_%0d_sub_count", n8), {59'b0, sc8}, 64'(e.sub));
        check($sformatf("op8_%0d_latency", n8), 64'(cyc - e.scyc), 64'(e.lat));
        n8++;
      end
    end
  end

  task automatic issue32(input logic m, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] al, input logic [5:0] bl, input exp_t e);
    int n = 0;
    @(negedge clk);
    while (rdy32 !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (rdy32 !== 1'b1) begin
      fail_now("ready32_timeout");
      return;
    end
    m32 = m; a32 = a; b32 = b; al32 = al; bl32 = bl; s32 = 1'b1;
    e.scyc = cyc;
    sb32.push_back(e);
    @(negedge clk);
    s32 = 1'b0;
  endtask

  task automatic issue8(input logic m, input logic [7:0] a, input logic [7:0] b, input exp_t e);
    int n = 0;
    @(negedge clk);
    while (rdy8 !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (rdy8 !== 1'b1) begin
      fail_now("ready8_timeout");
      return;
    end
    m8 = m; a8 = a; b8 = b; al8 = '0; bl8 = '0; s8 = 1'b1;
    e.scyc = cyc;
    sb8.push_back(e);
    @(negedge clk);
    s8 = 1'b0;
  endtask

  task automatic wait32();
    int n = 0;
    while (sb32.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    if (sb32.size() != 0) begin
      fail_now("done32_timeout");
      sb32.delete();
    end
  endtask

  task automatic wait8();
    int n = 0;
    while (sb8.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    if (sb8.size() != 0) begin
      fail_now("done8_timeout");
      sb8.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready32"}, {63'b0, rdy32}, 64'd1);
    check({tag, "_done32"}, {63'b0, dn32}, 64'd0);
    check({tag, "_quotient32"}, {32'b0, q32}, 64'd0);
    check({tag, "_remainder32"}, {32'b0, r32}, 64'd0);
    check({tag, "_add32"}, {57'b0, ac32}, 64'd0);
    check({tag, "_sub32"}, {57'b0, sc32}, 64'd0);
    check({tag, "_dbz32"}, {63'b0, dbz32}, 64'd0);
    check({tag, "_ready8"}, {63'b0, rdy8}, 64'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog_expired");
    $fatal(1, "watchdog");
  end

  initial begin
    tv_t         tbl[12];
    exp_t        e;
    exp_t        eb;
    logic [31:0] ra, rb;
    logic [7:0]  ra8, rb8;
    int          ca;
    int          n;

    tbl[0]  = '{1'b0, 32'd67,         32'd14, 6'd7,  6'd4, 32'd4,          32'd11,  1'b0, 6,  7,  9};
    tbl[1]  = '{1'b1, 32'd67,         32'd14, 6'd7,  6'd4, 32'd4,          32'd11,  1'b0, 6,  2,  9};
    tbl[2]  = '{1'b0, 32'd156,        32'd0,  6'd8,  6'd0, 32'hFFFF_FFFF,  32'd156, 1'b1, 0,  0,  1};
    tbl[3]  = '{1'b1, 32'd156,        32'd0,  6'd8,  6'd0, 32'hFFFF_FFFF,  32'd156, 1'b1, 0,  0,  1};
    tbl[4]  = '{1'b0, 32'd13,         32'd77, 6'd4,  6'd7, 32'd0,          32'd13,  1'b0, 0,  0,  1};
    tbl[5]  = '{1'b1, 32'd13,         32'd77, 6'd4,  6'd7, 32'd0,          32'd13,  1'b0, 0,  0,  1};
    tbl[6]  = '{1'b0, 32'd100,        32'd7,  6'd0,  6'd0, 32'd14,         32'd2,   1'b0, 29, 32, 34};
    tbl[7]  = '{1'b1, 32'hFFFF_FFFF,  32'd1,  6'd0,  6'd1, 32'hFFFF_FFFF,  32'd0,   1'b0, 0,  32, 34};
    tbl[8]  = '{1'b0, 32'd5,          32'd9,  6'd4,  6'd4, 32'd0,          32'd5,   1'b0, 4,  4,  6};
    tbl[9]  = '{1'b1, 32'd1000,       32'd33, 6'd40, 6'd6, 32'd30,         32'd10,  1'b0, 28, 5,  34};
    tbl[10] = '{1'b1, 32'hF3,         32'd2,  6'd4,  6'd2, 32'd1,          32'd1,   1'b0, 3,  1,  6};
    tbl[11] = '{1'b0, 32'hF3,         32'd2,  6'd4,  6'd2, 32'd1,          32'd1,   1'b0, 3,  4,  6};

    s32 = 1'b0; m32 = 1'b0; a32 = '0; b32 = '0; al32 = '0; bl32 = '0;
    s8  = 1'b0; m8  = 1'b0; a8  = '0; b8  = '0; al8  = '0; bl8  = '0;

    // Asynchronous reset takes effect without a clock edge
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    for (int i = 0; i < 12; i++) begin
      e = '{q: {32'b0, tbl[i].eq}, r: {32'b0, tbl[i].er}, dbz: tbl[i].ed,
            add: tbl[i].ea, sub: tbl[i].es, lat: tbl[i].el, scyc: 0};
      issue32(tbl[i].m, tbl[i].a, tbl[i].b, tbl[i].al, tbl[i].bl, e);
      wait32();
    end

    // Back-to-back: start held high through done; the second op is accepted the cycle after done
    n = 0;
    @(negedge clk);
    while (rdy32 !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    m32 = 1'b0; a32 = 32'd67; b32 = 32'd14; al32 = 6'd7; bl32 = 6'd4; s32 = 1'b1;
    ca = cyc;
    e  = '{q: 64'd4, r: 64'd11, dbz: 1'b0, add: 6, sub: 7, lat: 9, scyc: ca};
    eb = '{q: 64'd22, r: 64'd2, dbz: 1'b0, add: 5, sub: 4, lat: 10, scyc: ca + 10};
    sb32.push_back(e);
    sb32.push_back(eb);
    @(negedge clk);
    m32 = 1'b1; a32 = 32'd200; b32 = 32'd9; al32 = 6'd8; bl32 = 6'd4;
    n = 0;
    while (cyc < ca + 11 && n < 100) begin
      @(negedge clk);
      n++;
    end
    s32 = 1'b0;
    wait32();

    // Reset in the middle of RUN abandons the operation
    issue32(1'b0, 32'd99, 32'd14, 6'd0, 6'd0, model(32, 64'd99, 64'd14, 1'b0));
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1 check_reset_outputs("midrun_reset");
    sb32.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    issue32(1'b1, 32'd68, 32'd14, 6'd7, 6'd4,
            '{q: 64'd4, r: 64'd12, dbz: 1'b0, add: 6, sub: 2, lat: 9, scyc: 0});
    wait32();

    // Random sweeps, both algorithms, both widths
    for (int md = 0; md < 2; md++) begin
      for (int k = 0; k < 25; k++) begin
        ra = $urandom;
        rb = $urandom >> $urandom_range(0, 31);
        issue32(md[0], ra, rb, 6'd0, 6'd0, model(32, {32'b0, ra}, {32'b0, rb}, md[0]));
        wait32();
      end
      for (int k = 0; k < 25; k++) begin
        ra8 = 8'($urandom_range(0, 255));
        rb8 = 8'($urandom_range(0, 255) >> $urandom_range(0, 7));
        issue8(md[0], ra8, rb8, model(8, {56'b0, ra8}, {56'b0, rb8}, md[0]));
        wait8();
      end
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
